video_router_ctrl_pio: RTL and testbench

Parametrised Avalon-MM control port for the video subsystem's stream routers; generalises the single-bit router-select register to a WIDTH-bit select. Holds a software-written shadow value and, in sync mode, commits it to `out_port` only on a video frame boundary, so a router never switches mid-frame. Also reports pending/commit status and counts frame boundaries. Sits between the HPS/Nios Avalon bridge and the select inputs of the edge-detection (and other) stream routers.

---
 rtl/video_router_ctrl_pio_pkg.sv | 22 ++
 rtl/video_router_ctrl_pio_if.sv | 20 ++
 rtl/video_router_ctrl_pio_frame_counter.sv | 23 ++
 rtl/video_router_ctrl_pio.sv | 143 ++++++++++++++
 tb/tb_video_router_ctrl_pio.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_router_ctrl_pio_pkg.sv
// Register map constants shared by the video router control port.
// Optional feature macro used by the design: ROUTER_CTRL_IRQ_EN.
package video_router_ctrl_pkg;

    // Register offsets
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_CONTROL = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_FCOUNT  = 2'd3;

    // CONTROL bit positions
    localparam int unsigned SYNC_MODE_BIT = 0;
    localparam int unsigned IRQ_EN_BIT    = 1;

    // STATUS bit positions
    localparam int unsigned PENDING_BIT       = 0;
    localparam int unsigned COMMIT_FLAG_BIT   = 1;
    localparam int unsigned STATUS_SHADOW_LSB = 8;

    localparam int unsigned BUS_WIDTH = 32;

endpackage

// File: rtl/video_router_ctrl_pio_if.sv
// Avalon-MM slave bus bundle for the router control port.
// Signals: address, chipselect, write_n, writedata (master -> slave),
//          readdata (slave -> master, combinational, zero wait states).
interface video_router_ctrl_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/video_router_ctrl_pio_frame_counter.sv
// Wrapping frame-boundary counter; a clear has priority over an increment.
// Ports: clk, reset_n (sync, active-low), i_clear, i_inc, o_count.
module router_ctrl_frame_counter #(
    parameter int unsigned FCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clear,
    input  logic                  i_inc,
    output logic [FCNT_WIDTH-1:0] o_count
);

    logic [FCNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n)     r_count <= '0;
        else if (i_clear) r_count <= '0;
        else if (i_inc)   r_count <= r_count + FCNT_WIDTH'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/video_router_ctrl_pio.sv
// Avalon-MM control port driving a WIDTH-bit stream-router select. A software
// shadow value is committed immediately or, in sync mode, on a frame boundary.
// Ports: clk, reset_n (sync, active-low), avs (bus slave modport),
//        frame_sync (start-of-frame pulse), out_port (active select),
//        irq (commit interrupt, only when ROUTER_CTRL_IRQ_EN is defined).
module video_router_ctrl_pio
    import video_router_ctrl_pkg::*;
#(
    parameter int unsigned       WIDTH        = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE  = '0,
    parameter bit                SYNC_DEFAULT = 1'b1,
    parameter int unsigned       FCNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    video_router_ctrl_pio_if.slave avs,
    input  logic                 frame_sync,
    output logic [WIDTH-1:0]     out_port
`ifdef ROUTER_CTRL_IRQ_EN
    ,
    output logic                 irq
`endif
);

    logic [WIDTH-1:0]      r_active, r_shadow;
    logic                  r_pending, r_sync_mode;
    logic [WIDTH-1:0]      w_active_nxt, w_shadow_nxt;
    logic                  w_pending_nxt, w_sync_nxt;
    logic                  w_wr, w_wr_data, w_wr_ctrl, w_wr_status, w_wr_fcnt;
    logic                  w_commit_frame;
    logic                  w_commit_flag, w_irq_en;
    logic [FCNT_WIDTH-1:0] w_fcount;
    logic                  w_unused_wdata;

    // Bus decode
    assign w_wr           = avs.chipselect & ~avs.write_n;
    assign w_wr_data      = w_wr && (avs.address == ADDR_DATA);
    assign w_wr_ctrl      = w_wr && (avs.address == ADDR_CONTROL);
    assign w_wr_status    = w_wr && (avs.address == ADDR_STATUS);
    assign w_wr_fcnt      = w_wr && (avs.address == ADDR_FCOUNT);
    assign w_commit_frame = frame_sync & r_pending;
    assign w_unused_wdata = &{1'b0, avs.writedata};

    // Shadow/active/pending next-state; later assignments take priority
    always_comb begin
        w_active_nxt  = r_active;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = r_pending;
        w_sync_nxt    = r_sync_mode;
        if (w_wr_ctrl) w_sync_nxt = avs.writedata[SYNC_MODE_BIT];
        // a frame commit beats a same-cycle cancel
        if (w_commit_frame) begin
            w_active_nxt  = r_shadow;
            w_pending_nxt = 1'b0;
        end else if (w_wr_status && avs.writedata[PENDING_BIT]) begin
            w_pending_nxt = 1'b0;
        end
        // leaving sync mode flushes the pending shadow without raising the flag
        if (w_wr_ctrl && !avs.writedata[SYNC_MODE_BIT] && r_pending) begin
            w_active_nxt  = r_shadow;
            w_pending_nxt = 1'b0;
        end
        // a frame commit above uses the old shadow; the new value re-arms PENDING
        if (w_wr_data) begin
            w_shadow_nxt = avs.writedata[WIDTH-1:0];
            if (r_sync_mode) w_pending_nxt = 1'b1;
            else             w_active_nxt  = avs.writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_active    <= RESET_VALUE;
            r_shadow    <= RESET_VALUE;
            r_pending   <= 1'b0;
            r_sync_mode <= SYNC_DEFAULT;
        end else begin
            r_active    <= w_active_nxt;
            r_shadow    <= w_shadow_nxt;
            r_pending   <= w_pending_nxt;
            r_sync_mode <= w_sync_nxt;
        end
    end

`ifdef ROUTER_CTRL_IRQ_EN
    logic r_commit_flag, r_irq_en, r_irq;
    logic w_flag_nxt, w_irq_en_nxt;

    // Commit flag: set by frame commit (wins over a same-cycle clear)
    always_comb begin
        w_flag_nxt   = r_commit_flag;
        w_irq_en_nxt = r_irq_en;
        if (w_wr_status && avs.writedata[COMMIT_FLAG_BIT]) w_flag_nxt = 1'b0;
        if (w_commit_frame) w_flag_nxt = 1'b1;
        if (w_wr_ctrl) w_irq_en_nxt = avs.writedata[IRQ_EN_BIT];
    end

    // irq is registered from next-state so it rises with the commit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_commit_flag <= 1'b0;
            r_irq_en      <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_commit_flag <= w_flag_nxt;
            r_irq_en      <= w_irq_en_nxt;
            r_irq         <= w_flag_nxt & w_irq_en_nxt;
        end
    end

    assign w_commit_flag = r_commit_flag;
    assign w_irq_en      = r_irq_en;
    assign irq           = r_irq;
`else
    assign w_commit_flag = 1'b0;
    assign w_irq_en      = 1'b0;
`endif

    router_ctrl_frame_counter #(
        .FCNT_WIDTH (FCNT_WIDTH)
    ) u_frame_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_wr_fcnt),
        .i_inc   (frame_sync),
        .o_count (w_fcount)
    );

    // Zero-wait-state read mux
    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            ADDR_DATA:    avs.readdata = BUS_WIDTH'(r_active);
            ADDR_CONTROL: avs.readdata = BUS_WIDTH'({w_irq_en, r_sync_mode});
            ADDR_STATUS:  avs.readdata = (BUS_WIDTH'(r_shadow) << STATUS_SHADOW_LSB)
                                       | BUS_WIDTH'({w_commit_flag, r_pending});
            default:      avs.readdata = BUS_WIDTH'(w_fcount);
        endcase
    end

    assign out_port = r_active;

endmodule

// File: tb/tb_video_router_ctrl_pio.sv
// Scoreboard bench for video_router_ctrl_pio (WIDTH=2, FCNT_WIDTH=4).
// Stimulus pushes expected values; a negedge monitor pops and compares.
module tb_video_router_ctrl_pio;

    localparam int unsigned WIDTH = 2;
`ifdef ROUTER_CTRL_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif
    localparam logic [31:0] F   = IRQ_BUILD ? 32'h2 : 32'h0;
    localparam logic [31:0] IEN = IRQ_BUILD ? 32'h2 : 32'h0;

    localparam int K_RD  = 0;
    localparam int K_OUT = 1;
    localparam int K_IRQ = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             frame_sync;
    logic [WIDTH-1:0] out_port;
`ifdef ROUTER_CTRL_IRQ_EN
    logic             irq;
`endif

    video_router_ctrl_pio_if bus ();

    video_router_ctrl_pio #(
        .WIDTH        (WIDTH),
        .RESET_VALUE  (2'd0),
        .SYNC_DEFAULT (1'b1),
        .FCNT_WIDTH   (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .avs        (bus),
        .frame_sync (frame_sync),
        .out_port   (out_port)
`ifdef ROUTER_CTRL_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          kind_q[$];
    string       name_q[$];
    logic        chk_req = 1'b0;

    // Monitor: one scoreboard entry consumed per requested cycle
    always @(negedge clk) begin
        if (chk_req) begin
            logic [31:0] e, act;
            int          k;
            string       n;
            checks++;
            if (kind_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                k = kind_q.pop_front();
                e = exp_q.pop_front();
                n = name_q.pop_front();
                act = '0;
                case (k)
                    K_RD:  act = bus.readdata;
                    K_OUT: act = 32'(out_port);
`ifdef ROUTER_CTRL_IRQ_EN
                    K_IRQ: act = 32'(irq);
`endif
                    default: act = 32'hDEAD_BEEF;
                endcase
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, e, $time);
                end
            end
        end
    end

    // One bus cycle, starting just after a rising edge
    task automatic cyc(input logic cs, input logic wn, input logic [1:0] a,
                       input logic [31:0] d, input logic fs);
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = d;
        frame_sync     = fs;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        frame_sync     = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic fs);
        cyc(1'b1, 1'b0, a, d, fs);
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
    endtask

    task automatic chk(input int k, input logic [1:0] a, input logic [31:0] e, input string n);
        kind_q.push_back(k);
        exp_q.push_back(e);
        name_q.push_back(n);
        chk_req = 1'b1;
        cyc(k == K_RD, 1'b1, a, 32'd0, 1'b0);
        chk_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n        = 1'b0;
        frame_sync     = 1'b0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = 32'd0;
        @(posedge clk); #1;
        idle(3);
        reset_n = 1'b1;

        // Reset state
        chk(K_RD, 2'd0, 32'h0, "rst_data");
        chk(K_RD, 2'd2, 32'h0, "rst_status");
        chk(K_RD, 2'd1, 32'h1, "rst_control");
        chk(K_RD, 2'd3, 32'h0, "rst_fcount");
        chk(K_OUT, 2'd0, 32'h0, "rst_out");
`ifdef ROUTER_CTRL_IRQ_EN
        chk(K_IRQ, 2'd0, 32'h0, "rst_irq");
`endif

        // Sync commit on frame boundary
        wr(2'd1, 32'h3, 1'b0);
        chk(K_RD, 2'd1, 32'h1 | IEN, "ctrl_sync_irqen");
        wr(2'd0, 32'h3, 1'b0);
        idle(10);
        chk(K_OUT, 2'd0, 32'h0, "sync_hold_out");
        chk(K_RD, 2'd2, 32'h301, "sync_pending_status");
        pulse(1);
`ifdef ROUTER_CTRL_IRQ_EN
        chk(K_IRQ, 2'd0, 32'h1, "commit_irq");
`endif
        chk(K_OUT, 2'd0, 32'h3, "commit_out");
        chk(K_RD, 2'd2, 32'h300 | F, "commit_status");
        wr(2'd2, 32'h2, 1'b0);
        chk(K_RD, 2'd2, 32'h300, "flag_clear");
`ifdef ROUTER_CTRL_IRQ_EN
        chk(K_IRQ, 2'd0, 32'h0, "irq_clear");
`endif

        // Only the latest shadow commits
        wr(2'd0, 32'h1, 1'b0);
        wr(2'd0, 32'h2, 1'b0);
        chk(K_RD, 2'd2, 32'h201, "overwrite_status");
        pulse(1);
        chk(K_OUT, 2'd0, 32'h2, "overwrite_out");
        chk(K_RD, 2'd2, 32'h200 | F, "overwrite_commit_status");
        wr(2'd2, 32'h2, 1'b0);

        // DATA write coincident with frame_sync, PENDING=1
        wr(2'd0, 32'h3, 1'b0);
        pulse(1);
        chk(K_OUT, 2'd0, 32'h3, "pre_coinc_out");
        wr(2'd0, 32'h2, 1'b0);
        wr(2'd0, 32'h1, 1'b1);
        chk(K_OUT, 2'd0, 32'h2, "coinc_old_commit_out");
        chk(K_RD, 2'd2, 32'h101 | F, "coinc_status");
        pulse(1);
        chk(K_OUT, 2'd0, 32'h1, "coinc_followup_out");
        chk(K_RD, 2'd0, 32'h1, "coinc_data_read");

        // frame_sync without PENDING leaves flag alone
        wr(2'd2, 32'h2, 1'b0);
        pulse(1);
        chk(K_RD, 2'd2, 32'h100, "idle_frame_status");

        // DATA write coincident with frame_sync, PENDING=0
        wr(2'd0, 32'h2, 1'b1);
        chk(K_OUT, 2'd0, 32'h1, "coinc_nopend_out");
        chk(K_RD, 2'd2, 32'h201, "coinc_nopend_status");

        // Cancel keeps shadow, not applied
        wr(2'd2, 32'h1, 1'b0);
        chk(K_RD, 2'd2, 32'h200, "cancel_status");
        pulse(1);
        chk(K_OUT, 2'd0, 32'h1, "cancel_out");

        // Cancel and frame_sync together: commit wins
        wr(2'd0, 32'h3, 1'b0);
        wr(2'd2, 32'h1, 1'b1);
        chk(K_OUT, 2'd0, 32'h3, "cancel_vs_frame_out");
        chk(K_RD, 2'd2, 32'h300 | F, "cancel_vs_frame_status");
        wr(2'd2, 32'h2, 1'b0);

        // Leaving sync mode flushes pending shadow without flag
        wr(2'd0, 32'h0, 1'b0);
        wr(2'd1, 32'h2, 1'b0);
        chk(K_OUT, 2'd0, 32'h0, "flush_out");
        chk(K_RD, 2'd2, 32'h000, "flush_status");
        chk(K_RD, 2'd1, IEN, "flush_control");
`ifdef ROUTER_CTRL_IRQ_EN
        chk(K_IRQ, 2'd0, 32'h0, "flush_irq");
`endif

        // Immediate mode: N+1 latency, no PENDING
        wr(2'd0, 32'h1, 1'b0);
        chk(K_OUT, 2'd0, 32'h1, "immediate_out");
        chk(K_RD, 2'd2, 32'h100, "immediate_status");

        // Frame counter wrap and clear priority
        wr(2'd3, 32'h0, 1'b0);
        chk(K_RD, 2'd3, 32'h0, "fcount_clear");
        pulse(15);
        chk(K_RD, 2'd3, 32'd15, "fcount_15");
        pulse(2);
        chk(K_RD, 2'd3, 32'd1, "fcount_wrap");
        wr(2'd3, 32'h0, 1'b1);
        chk(K_RD, 2'd3, 32'd0, "fcount_clear_vs_frame");

        // Reset while PENDING discards shadow
        wr(2'd1, 32'h1, 1'b0);
        wr(2'd0, 32'h2, 1'b0);
        chk(K_RD, 2'd2, 32'h201, "pre_reset_status");
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        chk(K_RD, 2'd2, 32'h0, "post_reset_status");
        chk(K_OUT, 2'd0, 32'h0, "post_reset_out");
        chk(K_RD, 2'd1, 32'h1, "post_reset_control");
        pulse(1);
        chk(K_OUT, 2'd0, 32'h0, "post_reset_frame_out");
        chk(K_RD, 2'd2, 32'h0, "post_reset_frame_status");

        idle(2);
        checks++;
        if (kind_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", kind_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
